// File: rtl/free_idx_alloc.sv
// Free-index allocator: a circular queue of free slot indices feeding link_fifo pushes,
// with an in-use bitmap that rejects double frees. Loads 0..DEPTH-1 after reset.
module free_idx_alloc #(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned IDXW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            alloc_vld,
    input  logic            alloc_rdy,
    output logic [IDXW-1:0] alloc_idx,
    input  logic            free_vld,
    output logic            free_rdy,
    input  logic [IDXW-1:0] free_idx,
    output logic            init_done,
    output logic [IDXW:0]   free_count,
    output logic            err_free
);

    typedef enum logic {StInit, StRun} state_e;

    localparam logic [IDXW-1:0] MaxIdx = IDXW'(DEPTH - 1);
    localparam logic [IDXW-1:0] IdxOne = IDXW'(1);
    localparam logic [IDXW:0]   CntOne = (IDXW + 1)'(1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   init_cnt_q, init_cnt_d;
    logic [IDXW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IDXW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDXW:0]     free_count_q, free_count_d;
    logic [DEPTH-1:0]  inuse_q, inuse_d;
    logic              err_free_q, err_free_d;
    logic [IDXW-1:0]   mem_q [DEPTH];

    logic              run;
    logic              do_alloc;
    logic              do_free;
    logic              free_ok;
    logic              mem_we;
    logic [IDXW-1:0]   mem_waddr;
    logic [IDXW-1:0]   mem_wdata;

    assign run        = (state_q == StRun);
    assign alloc_vld  = run && (free_count_q != '0);
    assign alloc_idx  = run ? mem_q[rd_ptr_q] : '0;
    assign free_rdy   = run;
    assign init_done  = run;
    assign free_count = free_count_q;
    assign err_free   = err_free_q;

    assign do_alloc = alloc_vld && alloc_rdy;
    assign do_free  = run && free_vld;
    // inuse_q is sampled before this cycle's allocation takes effect, so freeing the
    // index being allocated right now is rejected.
    assign free_ok  = do_free && inuse_q[free_idx];

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        free_count_d = free_count_q;
        inuse_d      = inuse_q;
        err_free_d   = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q;
        mem_wdata    = free_idx;

        if (!run) begin
            mem_we       = 1'b1;
            mem_waddr    = init_cnt_q;
            mem_wdata    = init_cnt_q;
            init_cnt_d   = init_cnt_q + IdxOne;
            free_count_d = free_count_q + CntOne;
            if (init_cnt_q == MaxIdx) begin
                state_d    = StRun;
                init_cnt_d = '0;
            end
        end else begin
            if (do_alloc) begin
                rd_ptr_d           = (rd_ptr_q == MaxIdx) ? '0 : rd_ptr_q + IdxOne;
                inuse_d[alloc_idx] = 1'b1;
            end
            if (free_ok) begin
                mem_we            = 1'b1;
                wr_ptr_d          = (wr_ptr_q == MaxIdx) ? '0 : wr_ptr_q + IdxOne;
                inuse_d[free_idx] = 1'b0;
            end
            err_free_d = do_free && !free_ok;
            if (do_alloc && !free_ok) begin
                free_count_d = free_count_q - CntOne;
            end else if (free_ok && !do_alloc) begin
                free_count_d = free_count_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StInit;
            init_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            free_count_q <= '0;
            inuse_q      <= '0;
            err_free_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            free_count_q <= free_count_d;
            inuse_q      <= inuse_d;
            err_free_q   <= err_free_d;
        end
    end

    // Queue storage needs no reset: every entry is rewritten by the init fill.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: doc/free_idx_alloc.md
Name: free_idx_alloc

Overview:
Free-index allocator that sits directly upstream of link_fifo in the virtual-FIFO path. It supplies the wr_idx used for each push into the two-list queue, and it reclaims an index once that entry has been popped from either list. The free indices are held in an internal circular queue, and an in-use bitmap guards against double free. After reset, an init state machine loads indices 0..DEPTH-1 before the block accepts any traffic.

Parameters:
DEPTH, 32, number of shared slots; must be at least 2. Indices run 0..DEPTH-1.
IDXW, $clog2(DEPTH), index width (derived; not overridden).

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  reset; synchronous, active-low
alloc_vld  output  1  a free index is available on alloc_idx
alloc_rdy  input  1  consumer takes alloc_idx this cycle (driven by link_fifo push)
alloc_idx  output  IDXW  index at the head of the free queue
free_vld  input  1  free_idx is being returned
free_rdy  output  1  block accepts frees
free_idx  input  IDXW  index being returned (head of the popped list)
init_done  output  1  init fill complete; block is in RUN
free_count  output  IDXW+1  number of indices currently in the free queue
err_free  output  1  one-cycle pulse: rejected free of an index that is not in use

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=INIT, init_cnt=0, rd_ptr=0, wr_ptr=0, free_count=0, in-use bitmap all 0.
  - Outputs: alloc_vld=0, alloc_idx=0, free_rdy=0, init_done=0, err_free=0.
  - Applies in any state; reset mid-operation discards all allocations and restarts the init fill.
- INIT state:
  - Each cycle: mem[init_cnt]<=init_cnt, init_cnt++, free_count++.
  - alloc_vld=0 and free_rdy=0 throughout; free_vld and alloc_rdy are ignored.
  - When init_cnt==DEPTH-1 is written: go to RUN, with wr_ptr=0, rd_ptr=0, free_count=DEPTH.
  - Result: init_done=1 after exactly DEPTH rising edges with resetn=1.
- RUN state (stays in RUN until reset):
  - alloc_vld = (free_count!=0); alloc_idx = mem[rd_ptr]. The memory read is combinational.
  - free_rdy = 1.
- Allocate (alloc_vld & alloc_rdy):
  - rd_ptr advances, wrapping DEPTH-1 -> 0.
  - inuse[alloc_idx]<=1; free_count decrements.
  - alloc_rdy while alloc_vld=0 has no effect.
- Free (free_vld & free_rdy):
  - If inuse[free_idx]==1: mem[wr_ptr]<=free_idx, wr_ptr advances (wraps DEPTH-1 -> 0), inuse[free_idx]<=0, free_count increments.
  - Otherwise: the free is dropped, no state changes, and err_free=1 in the next cycle.
- Simultaneous allocate and free:
  - Both pointers advance and free_count is unchanged.
  - Freeing the same index that is being allocated in that cycle is an error: inuse is still 0 at that point, so the free is dropped and err_free pulses.
- Empty (free_count=0):
  - alloc_vld=0. There is no bypass path.
  - An index freed while empty appears on alloc_idx with alloc_vld=1 in the next cycle.
- Full: free_count never exceeds DEPTH, because only in-use indices are accepted back. No overflow path exists.
- Ordering: strict FIFO. After init, allocations come out 0,1,2,... and freed indices re-enter at the tail.
- Latency:
  - alloc: 0 cycles (combinational valid/index).
  - free -> reusable: 1 cycle.
  - err_free: 1 cycle after the offending handshake, 1 cycle wide.
- Arithmetic: pointers are IDXW bits with explicit wrap at DEPTH-1, so any DEPTH>=2 is supported. free_count is IDXW+1 bits.

Test Plan:
1. Release reset, hold alloc_rdy=0 -> init_done=0 for 31 cycles and 1 on cycle 32; free_count=32; alloc_vld=1; alloc_idx=0.
2. After init, alloc_rdy=1 for 32 cycles -> alloc_idx sequence 0..31; free_count falls to 0; alloc_vld=0 on cycle 33.
3. From empty, free idx 7 then idx 3 -> alloc_vld=1 the next cycle with alloc_idx=7; free_count=2; after one alloc, alloc_idx=3.
4. Free idx 5 while it is free (never allocated) -> err_free=1 for exactly one cycle; free_count unchanged; 5 is not duplicated in later allocations.
5. Steady state with free_count=10, alloc and free (of an in-use index) in the same cycle for 40 cycles -> free_count stays 10; pointers wrap cleanly; no err_free.
6. Allocate 12, then pull resetn low for one cycle mid-stream -> all outputs at reset values; init repeats in 32 cycles; allocation restarts at 0; freeing an old index then gives err_free=1.
